slink_tx_blockgen_stripe: RTL
=============================

# slink_tx_blockgen_stripe

Transmit-side 128b/13xb block generator and lane striper. Sits between the TX link layer / link-training controller and the per-lane TX gearbox/serializer, in the single TX link clock domain. Produces block-aligned, lane-synchronous framing for all active lanes: ordered-set blocks (TS1, TS2, SDS) and data blocks. This is the framing the RX block-align/deskew path locks and deskews against.

## Interface
- `DATA_WIDTH`, 8: per-lane beat width. Must divide 128; legal range 8..64.
- `NUM_LANES`, 4: physical lanes, power of 2, maximum 8.
- `BEATS`, 128/DATA_WIDTH: beats per block (derived).
- `clk` in 1: TX link clock. Single clock; **reset is synchronous and active-high**.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: block enable. Low forces IDLE immediately.
- `active_lanes` in 3: number of active lanes is `1<<active_lanes`, clamped to `NUM_LANES`.
- `train_req` in 2: 0 = idle, 1 = TS1, 2 = TS2, 3 = data (via SDS).
- `tx_stall` in 1: gearbox hold, common to all lanes.
- `ll_tx_data` in NUM_LANES*DATA_WIDTH: link-layer payload. Lane i uses slice i.
- `ll_tx_valid` in 1: payload valid.
- `ll_tx_ready` out 1: payload accepted this cycle when `ll_tx_valid` is also high.
- `tx_data_out` out NUM_LANES*DATA_WIDTH: per-lane beat.
- `tx_syncheader` out NUM_LANES*2: sync header; meaningful when `tx_startblock` is high.
- `tx_startblock` out NUM_LANES: first beat of a block.
- `tx_datavalid` out NUM_LANES: beat valid.
- `tx_state` out 3: current FSM state encoding.
- `tx_os_count` out 8: count of complete ordered-set blocks sent in the current state. Saturates at 255.
- `sds_sent` out 1: one-cycle pulse on the last beat of an SDS block.

## Operation
- FSM states: IDLE, TS1, TS2, SDS, DATA.
- Transitions from IDLE:
  - Evaluated in any cycle where `enable & ~tx_stall`.
  - req 1 → TS1, req 2 → TS2, req 3 → SDS, req 0 stays in IDLE.
- Transitions from all other states:
  - Taken only at a block boundary: `beat == BEATS-1 & ~tx_stall`.
  - From TS1, TS2 or SDS: req 0 → IDLE, req 1 → TS1, req 2 → TS2.
  - req 3 from TS1 or TS2 → SDS; req 3 from SDS or DATA → DATA.
  - From DATA: req 0/1/2 → IDLE/TS1/TS2.
  - SDS is always exactly one block.
- Beat counter:
  - Width `$clog2(BEATS)`.
  - Increments when the state is not IDLE and `~tx_stall`; wraps BEATS-1 → 0.
  - Cleared in IDLE.
- Block contents: 16 bytes per block. Byte k is carried in beat k/(DATA_WIDTH/8), little-endian within the beat.
  - TS1: header `2'b01`; byte0 `0x1E`, bytes 1..15 `0x4A`.
  - TS2: header `2'b01`; byte0 `0x2D`, bytes 1..15 `0x45`.
  - SDS: header `2'b01`; byte0 `0xE1`, bytes 1..15 `0x55`.
  - DATA: header `2'b10`. Each beat carries the `ll_tx_data` lane slice if accepted, else `0x00` fill. The block always completes.
- Handshake:
  - `ll_tx_ready = enable & (state==DATA) & ~tx_stall & ~data_exit`.
  - `data_exit` is high on the last beat of the final DATA block before leaving DATA.
  - `ll_tx_ready` is independent of `ll_tx_valid`.
- Lanes:
  - `active_lanes` is latched at each block start.
  - Inactive lanes output data 0, header 0, startblock 0, datavalid 0.
  - All active lanes share the same beat counter and headers, so lanes are identical apart from payload.
- `tx_os_count`:
  - Increments on the last beat of each TS1/TS2/SDS block.
  - Cleared on any state change and in IDLE.
- Reset or `enable` low, including mid-block:
  - Next cycle: state IDLE, counters 0, all outputs 0.
  - A partial block is abandoned. The RX side relocks on the next block.

## Timing
- Reset values: all outputs 0; `tx_state` = IDLE (3'd0).
- Output latency:
  - All framing outputs are registered, one cycle after the beat decision.
  - `train_req` sampled at edge t in IDLE → `tx_startblock`=1 on active lanes after edge t+1.
  - Data accepted at edge t → appears on `tx_data_out` after edge t+1.
- Stall:
  - While `tx_stall`=1, all counters and state hold.
  - `tx_datavalid` = 0 on the next cycle. Data, header and startblock outputs hold their last values.
- Simultaneous events:
  - `reset` overrides `enable`.
  - `enable` low overrides `tx_stall`.
  - A boundary coinciding with a `train_req` change uses the value sampled on the boundary cycle.

## Structure
- Package `slink_tx_pkg`:
  - State enum.
  - Sync-header constants: `SH_DATA=2'b10`, `SH_OS=2'b01`.
  - Symbol constants: TS1/TS2/SDS identifiers and fill bytes.
- Sub-module `slink_tx_os_pattern`: combinational map of (state, beat) → DATA_WIDTH-bit ordered-set beat. Instanced once and shared by all lanes.

## Test plan
- DATA_WIDTH=8, 4 lanes, train_req=1 from reset release:
  - 16-beat blocks; startblock every 16th beat; header 01; beat0=0x1E, beats 1..15=0x4A.
  - `tx_os_count` increments once per block.
- TS2 → train_req=3:
  - Exactly one SDS block (0xE1 then 15×0x55), with `sds_sent` pulsing on beat 15.
  - Then DATA blocks with header 10 and `ll_tx_ready`=1.
- DATA with `ll_tx_valid` toggling every other cycle: accepted slices appear one cycle later; unaccepted beats carry 0x00; block length stays 16.
- `tx_stall` asserted on beat 7 for 3 cycles: `tx_datavalid`=0 for 3 cycles, beat 7 resumes, and no beats are lost.
- active_lanes=1 with NUM_LANES=4: lanes 2-3 remain all-zero. Changing active_lanes mid-block takes effect only at the next startblock.
- `reset` pulsed on beat 5 of DATA: all outputs 0 next cycle; with train_req=1, a fresh TS1 block starts 2 cycles after reset deasserts.

Source files
------------

// File: rtl/slink_tx_pkg.sv
// Shared types and constants for the TX block generator / lane striper.
package slink_tx_pkg;

  // Framing FSM states; the encoding is visible on the tx_state output.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TS1  = 3'd1,
    ST_TS2  = 3'd2,
    ST_SDS  = 3'd3,
    ST_DATA = 3'd4
  } tx_state_e;

  // Sync headers.
  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_OS   = 2'b01;

  // Ordered-set identifiers (byte 0) and fill bytes (bytes 1..15).
  localparam logic [7:0] TS1_ID   = 8'h1E;
  localparam logic [7:0] TS1_FILL = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h2D;
  localparam logic [7:0] TS2_FILL = 8'h45;
  localparam logic [7:0] SDS_ID   = 8'hE1;
  localparam logic [7:0] SDS_FILL = 8'h55;

  // State chosen for a train_req value. A data request goes through a single
  // SDS block first unless we are already in SDS or DATA.
  function automatic tx_state_e next_state(input tx_state_e cur, input logic [1:0] req);
    tx_state_e nxt;
    case (req)
      2'd0:    nxt = ST_IDLE;
      2'd1:    nxt = ST_TS1;
      2'd2:    nxt = ST_TS2;
      default: nxt = (cur == ST_SDS || cur == ST_DATA) ? ST_DATA : ST_SDS;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/slink_tx_os_pattern.sv
// Combinational ordered-set beat generator: (state, beat) -> one lane beat.
// Produces zero for IDLE and DATA; shared by all lanes.
module slink_tx_os_pattern
  import slink_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BEATS      = 128 / DATA_WIDTH,
  parameter int BW         = $clog2(BEATS)
) (
  input  tx_state_e             state,
  input  logic [BW-1:0]         beat,
  output logic [DATA_WIDTH-1:0] os_beat
);

  localparam int BPB = DATA_WIDTH / 8;

  logic [7:0] id;
  logic [7:0] fill;

  // Byte 0 of the block (beat 0, low byte) carries the identifier, every
  // other byte carries the fill symbol.
  always_comb begin
    id      = 8'h00;
    fill    = 8'h00;
    os_beat = '0;
    case (state)
      ST_TS1: begin id = TS1_ID; fill = TS1_FILL; end
      ST_TS2: begin id = TS2_ID; fill = TS2_FILL; end
      ST_SDS: begin id = SDS_ID; fill = SDS_FILL; end
      default: begin id = 8'h00; fill = 8'h00; end
    endcase
    for (int j = 0; j < BPB; j++) begin
      os_beat[j*8 +: 8] = (beat == '0 && j == 0) ? id : fill;
    end
  end

endmodule

// File: rtl/slink_tx_blockgen_stripe.sv
// TX block generator and lane striper: emits lane-synchronous TS1/TS2/SDS
// ordered-set blocks and DATA blocks on all active lanes.
//
// Handshake: ll_tx_ready is a pure function of state (never of ll_tx_valid);
// a payload beat transfers on a rising edge where ll_tx_ready and
// ll_tx_valid are both high, and appears on tx_data_out after that edge.
module slink_tx_blockgen_stripe
  import slink_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int BEATS      = 128 / DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [2:0]                      active_lanes,
  input  logic [1:0]                      train_req,
  input  logic                            tx_stall,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] ll_tx_data,
  input  logic                            ll_tx_valid,
  output logic                            ll_tx_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] tx_data_out,
  output logic [NUM_LANES*2-1:0]          tx_syncheader,
  output logic [NUM_LANES-1:0]            tx_startblock,
  output logic [NUM_LANES-1:0]            tx_datavalid,
  output logic [2:0]                      tx_state,
  output logic [7:0]                      tx_os_count,
  output logic                            sds_sent
);

  localparam int              BW        = $clog2(BEATS);
  localparam int              LANE_LOG  = $clog2(NUM_LANES);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);

  tx_state_e                       state;
  tx_state_e                       nxt;
  logic [BW-1:0]                   beat;
  logic                            is_last;
  logic                            data_exit;
  logic                            accept;
  logic [NUM_LANES-1:0]            lane_mask_q;
  logic [NUM_LANES-1:0]            new_mask;
  logic [NUM_LANES-1:0]            lane_mask;
  logic [DATA_WIDTH-1:0]           os_beat;
  logic [1:0]                      sh;
  logic [NUM_LANES*DATA_WIDTH-1:0] beat_data;
  logic [NUM_LANES*2-1:0]          beat_sh;
  logic [NUM_LANES-1:0]            beat_sb;
  logic [NUM_LANES-1:0]            beat_dv;

  slink_tx_os_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (BEATS),
    .BW         (BW)
  ) u_os_pattern (
    .state   (state),
    .beat    (beat),
    .os_beat (os_beat)
  );

  assign nxt         = next_state(state, train_req);
  assign is_last     = (beat == LAST_BEAT);
  assign data_exit   = (state == ST_DATA) && is_last && (nxt != ST_DATA);
  assign ll_tx_ready = enable & (state == ST_DATA) & ~tx_stall & ~data_exit;
  assign accept      = ll_tx_ready & ll_tx_valid;
  assign tx_state    = state;

  // Build the beat every active lane would emit this cycle. The lane mask is
  // taken fresh on beat 0 and held from the latch for the rest of the block.
  always_comb begin
    new_mask  = '0;
    beat_data = '0;
    beat_sh   = '0;
    beat_sb   = '0;
    beat_dv   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      new_mask[i] = (int'(active_lanes) >= LANE_LOG) || (i < (1 << active_lanes));
    end
    lane_mask = (beat == '0) ? new_mask : lane_mask_q;
    sh        = (state == ST_DATA) ? SH_DATA : SH_OS;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_mask[i]) begin
        if (state == ST_DATA) begin
          beat_data[i*DATA_WIDTH +: DATA_WIDTH] =
            accept ? ll_tx_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end else begin
          beat_data[i*DATA_WIDTH +: DATA_WIDTH] = os_beat;
        end
        beat_sh[i*2 +: 2] = sh;
        beat_sb[i]        = (beat == '0);
        beat_dv[i]        = 1'b1;
      end
    end
  end

  // Framing FSM, beat counter, OS counter and registered lane outputs.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state         <= ST_IDLE;
      beat          <= '0;
      tx_os_count   <= '0;
      lane_mask_q   <= '0;
      tx_data_out   <= '0;
      tx_syncheader <= '0;
      tx_startblock <= '0;
      tx_datavalid  <= '0;
      sds_sent      <= 1'b0;
    end else if (tx_stall) begin
      // Everything holds; only the valid/pulse outputs drop.
      tx_datavalid <= '0;
      sds_sent     <= 1'b0;
    end else if (state == ST_IDLE) begin
      state         <= nxt;
      beat          <= '0;
      tx_os_count   <= '0;
      tx_data_out   <= '0;
      tx_syncheader <= '0;
      tx_startblock <= '0;
      tx_datavalid  <= '0;
      sds_sent      <= 1'b0;
    end else begin
      tx_data_out   <= beat_data;
      tx_syncheader <= beat_sh;
      tx_startblock <= beat_sb;
      tx_datavalid  <= beat_dv;
      sds_sent      <= (state == ST_SDS) && is_last;
      if (beat == '0) begin
        lane_mask_q <= new_mask;
      end
      beat <= is_last ? '0 : beat + 1'b1;
      if (is_last) begin
        state <= nxt;
        if (nxt != state) begin
          tx_os_count <= '0;
        end else if (state != ST_DATA && tx_os_count != 8'hFF) begin
          tx_os_count <= tx_os_count + 8'd1;
        end
      end
    end
  end

endmodule
